// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned LATENCY_MAX = 15;

  // Size code 11 is presented to the memory as a plain word access.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_WORD : s;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Two-way winner select: fixed priority (port 0), or round-robin on ties
// when ARB_ROUND_ROBIN_EN is defined.
module arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       idx,
  output logic       valid
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    valid = |req;
    idx   = 1'b0;
    if (req == 2'b11) idx = ~last;
    else              idx = req[1];
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    valid = |req;
    idx   = req[1] & ~req[0];
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises processor (port 0) and loader (port 1) accesses onto the single
// data-memory port. Optional tie-breaking macro: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  input  logic [1:0]        size0,
  input  logic [1:0]        size1,
  output logic              ack0,
  output logic              ack1,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [1:0]        mem_size,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  arb_state_t        state, state_nxt;
  logic [3:0]        cnt;
  logic              owner;
  logic              cmd_wr;
  logic              nxt_wr;
  logic              pick_idx, pick_valid;
  logic              last;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [1:0]        sel_size;

`ifndef ARB_ROUND_ROBIN_EN
  assign last = 1'b0;
`endif

  arb_pick u_pick (
    .req   ({req1, req0}),
    .last  (last),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    sel_wr    = pick_idx ? wr1    : wr0;
    sel_addr  = pick_idx ? addr1  : addr0;
    sel_wdata = pick_idx ? wdata1 : wdata0;
    sel_size  = pick_idx ? size1  : size0;
  end

  always_comb begin
    state_nxt = state;
    nxt_wr    = cmd_wr;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = ACCESS;
          nxt_wr    = sel_wr;
        end
      end
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mem_addr/mem_wdata/mem_size double as the command registers; enables,
  // acks and busy are registered from the next state so every output is a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      cmd_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= SZ_WORD;
      rdata     <= '0;
      mem_rden  <= 1'b0;
      mem_wren  <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      mem_rden <= (state_nxt == ACCESS) && !nxt_wr;
      mem_wren <= (state_nxt == ACCESS) &&  nxt_wr;
      ack0     <= (state_nxt == DONE) && !owner;
      ack1     <= (state_nxt == DONE) &&  owner;
      busy     <= (state_nxt != IDLE);
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_idx;
            cmd_wr    <= sel_wr;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_size  <= norm_size(sel_size);
            cnt       <= CNT_LOAD;
`ifdef ARB_ROUND_ROBIN_EN
            last      <= pick_idx;
`endif
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!cmd_wr) rdata <= mem_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
